// File: rtl/ahb_mtx_arbiter_param_pkg.sv
// Shared AHB transfer/burst codes and helpers for the
// bus-matrix output-stage arbiter.
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int REM_W   = 4;
  localparam int EARLY_W = 2;

  // Beats still to hold after the NONSEQ and the next SEQ.
  function automatic logic [REM_W-1:0] burst_remain(
    input hburst_e b
  );
    logic [REM_W-1:0] r;
    r = '0;
    unique case (b)
      HB_WRAP4,  HB_INCR4:  r = 4'd2;
      HB_WRAP8,  HB_INCR8:  r = 4'd6;
      HB_WRAP16, HB_INCR16: r = 4'd14;
      default:              r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb_mtx_arbiter_param_if.sv
// Request/owner/grant bundle between the matrix
// input stages and one output-stage arbiter.
interface ahb_mtx_arbiter_param_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 3
);

  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;
  logic                 burst_hold;

  modport master (
    output req_port,
    output HREADYM,
    output HSELM,
    output HTRANSM,
    output HBURSTM,
    output HMASTLOCKM,
    input  addr_in_port,
    input  no_port,
    input  burst_hold
  );

  modport slave (
    input  req_port,
    input  HREADYM,
    input  HSELM,
    input  HTRANSM,
    input  HBURSTM,
    input  HMASTLOCKM,
    output addr_in_port,
    output no_port,
    output burst_hold
  );

endinterface

// File: rtl/ahb_mtx_burst_tracker.sv
// Tracks the owner's burst so the grant is held until
// the address phase of the last beat.
module ahb_mtx_burst_tracker
  import ahb_mtx_pkg::*;
#(
  parameter int INCR_HOLD_BEATS  = 4,
  parameter int EARLY_INCR_LIMIT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ready,
  input  logic       i_sel,
  input  logic [1:0] i_trans,
  input  logic [2:0] i_burst,
  output logic       o_next_hold,
  output logic       o_hold
);

  localparam logic [REM_W-1:0] INCR_REM =
    REM_W'(INCR_HOLD_BEATS - 2);
  localparam logic [EARLY_W-1:0] EARLY_MAX =
    EARLY_W'(EARLY_INCR_LIMIT);

  logic [REM_W-1:0]   r_remain;
  logic [REM_W-1:0]   w_remain;
  logic               r_hold;
  logic               w_hold;
  logic [EARLY_W-1:0] r_early;
  logic [EARLY_W-1:0] w_early;
  logic               w_nonseq;
  htrans_e            w_trans;
  hburst_e            w_burst;

  assign w_trans  = htrans_e'(i_trans);
  assign w_burst  = hburst_e'(i_burst);
  assign w_nonseq = i_sel && (w_trans == HT_NONSEQ);

  always_comb begin
    w_remain = r_remain;
    w_hold   = r_hold;
    if (!i_sel) begin
      w_remain = '0;
      w_hold   = 1'b0;
    end else begin
      unique case (w_trans)
        HT_IDLE: begin
          w_remain = '0;
          w_hold   = 1'b0;
        end
        HT_BUSY: begin
          w_remain = r_remain;
        end
        HT_NONSEQ: begin
          unique case (w_burst)
            HB_SINGLE: begin
              w_remain = '0;
              w_hold   = 1'b0;
            end
            // Too many early restarts: stop holding INCR.
            HB_INCR: begin
              if (r_early == EARLY_MAX) begin
                w_remain = '0;
                w_hold   = 1'b0;
              end else begin
                w_remain = INCR_REM;
                w_hold   = 1'b1;
              end
            end
            default: begin
              w_remain = burst_remain(w_burst);
              w_hold   = 1'b1;
            end
          endcase
        end
        HT_SEQ: begin
          if (r_remain == '0) begin
            w_hold = 1'b0;
          end else begin
            w_remain = r_remain - 1'b1;
          end
        end
        default: begin
          w_remain = 'x;
          w_hold   = 1'bx;
        end
      endcase
    end
  end

  always_comb begin
    w_early = r_early;
    if (!w_hold) begin
      w_early = '0;
    end else if (w_nonseq && r_hold &&
                 (r_early != EARLY_MAX)) begin
      w_early = r_early + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_remain <= '0;
      r_hold   <= 1'b0;
      r_early  <= '0;
    end else if (i_ready) begin
      r_remain <= w_remain;
      r_hold   <= w_hold;
      r_early  <= w_early;
    end
  end

  assign o_next_hold = w_hold;
  assign o_hold      = r_hold;

endmodule

// File: rtl/ahb_mtx_arbiter_param.sv
// Output-stage arbiter: selects which input port drives
// one shared slave, round-robin or fixed priority.
module ahb_mtx_arbiter_param
  import ahb_mtx_pkg::*;
#(
  parameter int NUM_PORTS        = 4,
  parameter int PORT_W           = 3,
  parameter int ARB_MODE         = 0,
  parameter int INCR_HOLD_BEATS  = 4,
  parameter int EARLY_INCR_LIMIT = 1
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_mtx_arbiter_param_if.slave bus
);

  localparam bit PARAM_OK =
    (NUM_PORTS >= 2) && (NUM_PORTS <= 15) &&
    ((2 ** PORT_W) > NUM_PORTS) &&
    ((ARB_MODE == ARB_RR) || (ARB_MODE == ARB_FIXED)) &&
    (INCR_HOLD_BEATS >= 2) && (INCR_HOLD_BEATS <= 16) &&
    (EARLY_INCR_LIMIT >= 1) && (EARLY_INCR_LIMIT <= 3);

  logic [PORT_W-1:0] r_addr;
  logic [PORT_W-1:0] w_addr;
  logic              r_none;
  logic              w_none;
  logic              w_next_hold;
  logic              w_hold;
  logic [PORT_W-1:0] w_lo;
  logic              w_lo_ok;
  logic [PORT_W-1:0] w_up;
  logic              w_up_ok;
  logic [PORT_W-1:0] w_dn;
  logic              w_dn_ok;
  logic              w_cur_req;

  ahb_mtx_burst_tracker #(
    .INCR_HOLD_BEATS  (INCR_HOLD_BEATS),
    .EARLY_INCR_LIMIT (EARLY_INCR_LIMIT)
  ) u_trk (
    .i_clk       (HCLK),
    .i_rst_n     (HRESETn),
    .i_ready     (bus.HREADYM),
    .i_sel       (bus.HSELM),
    .i_trans     (bus.HTRANSM),
    .i_burst     (bus.HBURSTM),
    .o_next_hold (w_next_hold),
    .o_hold      (w_hold)
  );

  // lo: lowest requester; up/dn: first above/below owner.
  always_comb begin
    w_lo      = '0;
    w_lo_ok   = 1'b0;
    w_up      = '0;
    w_up_ok   = 1'b0;
    w_dn      = '0;
    w_dn_ok   = 1'b0;
    w_cur_req = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (bus.req_port[i-1]) begin
        if (!w_lo_ok) begin
          w_lo    = PORT_W'(i);
          w_lo_ok = 1'b1;
        end
        if (PORT_W'(i) > r_addr && !w_up_ok) begin
          w_up    = PORT_W'(i);
          w_up_ok = 1'b1;
        end
        if (PORT_W'(i) < r_addr && !w_dn_ok) begin
          w_dn    = PORT_W'(i);
          w_dn_ok = 1'b1;
        end
        if (PORT_W'(i) == r_addr) begin
          w_cur_req = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_addr = r_addr;
    w_none = r_none;
    if (!(bus.HMASTLOCKM || w_next_hold)) begin
      if (r_none) begin
        if (w_lo_ok) begin
          w_addr = w_lo;
          w_none = 1'b0;
        end
      end else if (ARB_MODE == ARB_RR) begin
        if (w_up_ok) begin
          w_addr = w_up;
        end else if (w_dn_ok) begin
          w_addr = w_dn;
        end else if (!bus.HSELM) begin
          w_none = 1'b1;
        end
      end else begin
        if (w_dn_ok) begin
          w_addr = w_dn;
        end else if (bus.HSELM || w_cur_req) begin
          w_addr = r_addr;
        end else if (w_lo_ok) begin
          w_addr = w_lo;
        end else begin
          w_none = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr <= '0;
      r_none <= 1'b1;
    end else if (bus.HREADYM) begin
      r_addr <= w_addr;
      r_none <= w_none;
    end
  end

  assign bus.addr_in_port = r_addr;
  assign bus.no_port      = r_none;
  assign bus.burst_hold   = w_hold;

  a_params: assert property (
    @(posedge HCLK) PARAM_OK
  );

  a_addr_range: assert property (
    @(posedge HCLK) disable iff (!HRESETn)
      r_addr <= PORT_W'(NUM_PORTS)
  );

endmodule

// File: tb/tb_ahb_mtx_arbiter_param.sv
// Directed plus random stimulus against a beat-counting
// reference model, for one RR and one fixed instance.
module tb_ahb_mtx_arbiter_param;
  import ahb_mtx_pkg::*;

  localparam int NP  = 4;
  localparam int PW  = 3;
  localparam int HB  = 4;
  localparam int LIM = 1;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  always #5 HCLK = ~HCLK;

  logic [NP-1:0] req;
  logic          rdy;
  logic          sel;
  logic [1:0]    tr;
  logic [2:0]    bu;
  logic          lk;

  ahb_mtx_arbiter_param_if #(.NUM_PORTS(NP), .PORT_W(PW))
    bus_rr ();
  ahb_mtx_arbiter_param_if #(.NUM_PORTS(NP), .PORT_W(PW))
    bus_fx ();

  assign bus_rr.req_port   = req;
  assign bus_rr.HREADYM    = rdy;
  assign bus_rr.HSELM      = sel;
  assign bus_rr.HTRANSM    = tr;
  assign bus_rr.HBURSTM    = bu;
  assign bus_rr.HMASTLOCKM = lk;
  assign bus_fx.req_port   = req;
  assign bus_fx.HREADYM    = rdy;
  assign bus_fx.HSELM      = sel;
  assign bus_fx.HTRANSM    = tr;
  assign bus_fx.HBURSTM    = bu;
  assign bus_fx.HMASTLOCKM = lk;

  ahb_mtx_arbiter_param #(
    .NUM_PORTS(NP), .PORT_W(PW), .ARB_MODE(0),
    .INCR_HOLD_BEATS(HB), .EARLY_INCR_LIMIT(LIM)
  ) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_rr)
  );

  ahb_mtx_arbiter_param #(
    .NUM_PORTS(NP), .PORT_W(PW), .ARB_MODE(1),
    .INCR_HOLD_BEATS(HB), .EARLY_INCR_LIMIT(LIM)
  ) u_fx (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_fx)
  );

  int checks = 0;
  int errors = 0;

  // Model: owner per instance (0 = none) and burst beats.
  int own_rr, own_fx;
  int m_beats, m_len, m_early;
  bit m_hold;

  function automatic int blen(input bit [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd1:       return HB;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic int arb(
    input int mode, input int cur, input bit [NP-1:0] r,
    input bit s, input bit l, input bit nh
  );
    int order[$];
    if (l || nh) return cur;
    if (cur == 0) begin
      for (int i = 1; i <= NP; i++)
        if (r[i-1]) return i;
      return 0;
    end
    if (mode == 0) begin
      for (int i = cur + 1; i <= NP; i++) order.push_back(i);
      for (int i = 1; i < cur; i++) order.push_back(i);
      foreach (order[j])
        if (r[order[j]-1]) return order[j];
      return s ? cur : 0;
    end
    for (int i = 1; i < cur; i++)
      if (r[i-1]) return i;
    if (s || r[cur-1]) return cur;
    for (int i = cur + 1; i <= NP; i++)
      if (r[i-1]) return i;
    return 0;
  endfunction

  task automatic chk(
    input string tag, input int obs, input int exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rr_none", int'(bus_rr.no_port), int'(own_rr == 0));
    if (own_rr != 0)
      chk("rr_addr", int'(bus_rr.addr_in_port), own_rr);
    chk("rr_hold", int'(bus_rr.burst_hold), int'(m_hold));
    chk("fx_none", int'(bus_fx.no_port), int'(own_fx == 0));
    if (own_fx != 0)
      chk("fx_addr", int'(bus_fx.addr_in_port), own_fx);
    chk("fx_hold", int'(bus_fx.burst_hold), int'(m_hold));
  endtask

  task automatic model_reset();
    own_rr  = 0;
    own_fx  = 0;
    m_beats = 0;
    m_len   = 0;
    m_early = 0;
    m_hold  = 1'b0;
  endtask

  task automatic step(
    input bit [NP-1:0] r, input bit rd, input bit s,
    input bit [1:0] t, input bit [2:0] b, input bit l
  );
    bit nh;
    int nb, nl, ne, nrr, nfx;
    req = r; rdy = rd; sel = s; tr = t; bu = b; lk = l;
    nh = m_hold; nb = m_beats; nl = m_len;
    if (!s || t == 2'd0) begin
      nh = 1'b0; nb = 0; nl = 0;
    end else if (t == 2'd2) begin
      nb = 1;
      if (b == 3'd1) nl = (m_early == LIM) ? 1 : HB;
      else nl = blen(b);
      nh = (nb < nl);
    end else if (t == 2'd3) begin
      nb = m_beats + 1;
      nh = m_hold && (nb < nl);
    end
    if (!nh) ne = 0;
    else if (t == 2'd2 && m_hold && m_early < LIM)
      ne = m_early + 1;
    else ne = m_early;
    nrr = arb(0, own_rr, r, s, l, nh);
    nfx = arb(1, own_fx, r, s, l, nh);
    @(posedge HCLK);
    #1;
    if (rd) begin
      own_rr  = nrr;
      own_fx  = nfx;
      m_hold  = nh;
      m_beats = nb;
      m_len   = nl;
      m_early = ne;
    end
    check_all();
  endtask

  int exp_seq[4];
  int rv;

  initial begin
    req = '0; rdy = 1'b1; sel = 1'b0;
    tr = HT_IDLE; bu = HB_SINGLE; lk = 1'b0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_rr_none", int'(bus_rr.no_port), 1);
    chk("rst_rr_addr", int'(bus_rr.addr_in_port), 0);
    chk("rst_rr_hold", int'(bus_rr.burst_hold), 0);
    chk("rst_fx_none", int'(bus_fx.no_port), 1);
    chk("rst_fx_addr", int'(bus_fx.addr_in_port), 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Idle, then first grant to lowest requester.
    step(4'b0000, 1, 0, HT_IDLE, HB_SINGLE, 0);
    step(4'b0101, 1, 0, HT_IDLE, HB_SINGLE, 0);
    chk("t1_addr", int'(bus_rr.addr_in_port), 1);
    chk("t1_none", int'(bus_rr.no_port), 0);

    // Round-robin rotation over singles.
    exp_seq = '{3, 4, 1, 3};
    for (int i = 0; i < 4; i++) begin
      step(4'b1101, 1, 1, HT_NONSEQ, HB_SINGLE, 0);
      chk("t2_rr_seq", int'(bus_rr.addr_in_port),
          exp_seq[i]);
    end

    // INCR8 by port 2 holds through beat 8.
    step(4'b0010, 1, 1, HT_NONSEQ, HB_SINGLE, 0);
    chk("t3_own2", int'(bus_rr.addr_in_port), 2);
    step(4'b1111, 1, 1, HT_NONSEQ, HB_INCR8, 0);
    chk("t3_held", int'(bus_rr.addr_in_port), 2);
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, 1, 1, HT_SEQ, HB_INCR8, 0);
      chk("t3_held", int'(bus_rr.addr_in_port), 2);
    end
    step(4'b1111, 1, 1, HT_SEQ, HB_INCR8, 0);
    chk("t3_moved", int'(bus_rr.addr_in_port), 3);

    // Early-terminated INCR restarts.
    step(4'b1111, 1, 1, HT_NONSEQ, HB_INCR, 0);
    chk("t4_hold1", int'(bus_rr.burst_hold), 1);
    step(4'b1111, 1, 1, HT_SEQ, HB_INCR, 0);
    step(4'b1111, 1, 1, HT_NONSEQ, HB_INCR, 0);
    chk("t4_hold2", int'(bus_rr.burst_hold), 1);
    chk("t4_keep", int'(bus_rr.addr_in_port), 3);
    step(4'b1111, 1, 1, HT_SEQ, HB_INCR, 0);
    step(4'b1111, 1, 1, HT_NONSEQ, HB_INCR, 0);
    chk("t4_refused", int'(bus_rr.burst_hold), 0);
    chk("t4_moved", int'(bus_rr.addr_in_port), 4);

    // Fixed priority preemption and lock.
    step(4'b0100, 1, 0, HT_IDLE, HB_SINGLE, 0);
    chk("t5_fx3", int'(bus_fx.addr_in_port), 3);
    step(4'b0100, 1, 1, HT_NONSEQ, HB_SINGLE, 0);
    step(4'b0101, 1, 1, HT_NONSEQ, HB_SINGLE, 0);
    chk("t5_fx1", int'(bus_fx.addr_in_port), 1);
    step(4'b0100, 1, 0, HT_IDLE, HB_SINGLE, 0);
    chk("t5_fx3b", int'(bus_fx.addr_in_port), 3);
    step(4'b0101, 1, 1, HT_NONSEQ, HB_SINGLE, 1);
    chk("t5_lock", int'(bus_fx.addr_in_port), 3);

    // HREADYM low freezes everything, then async reset.
    step(4'b1111, 1, 1, HT_NONSEQ, HB_INCR4, 0);
    chk("t6_hold", int'(bus_rr.burst_hold), 1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 0, 0, HT_IDLE, HB_SINGLE, 0);
      chk("t6_frz_hold", int'(bus_rr.burst_hold), 1);
    end
    step(4'b1111, 1, 1, HT_SEQ, HB_INCR4, 0);
    chk("t6_still", int'(bus_rr.burst_hold), 1);
    #2;
    HRESETn = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_none", int'(bus_rr.no_port), 1);
    chk("t6_rst_hold", int'(bus_rr.burst_hold), 0);
    chk("t6_rst_fx", int'(bus_fx.no_port), 1);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      rv = $urandom_range(0, 9);
      step(NP'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 8,
           (rv == 0) ? 2'd0 : (rv == 1) ? 2'd1 :
           (rv < 5)  ? 2'd2 : 2'd3,
           3'($urandom_range(0, 7)),
           $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
